instruction_decode_stage: RTL and testbench
===========================================

// Module: instruction_decode_stage
// PURPOSE
//  Registered ARM-subset decode stage between fetch and execute. Decodes data-processing, branch/BL and
//  LDR/STR words, evaluates the condition field, expands rotated immediates and computes branch targets.
//  Results are buffered in a DEPTH-entry FIFO with valid/ready handshakes on both sides, plus a flush input.
// PARAMETERS
//  DATA_WIDTH    32  datapath width for imm/pc/target; must be >= 32
//  ALUCTL_WIDTH  11  width of out_alu_code
//  DEPTH          2  decoded-entry FIFO depth; power of two, >= 2
// PORTS
//  clk           in   1             clock, rising edge
//  rst_n         in   1             asynchronous active-low reset
//  flush         in   1             synchronous discard of all buffered entries
//  in_valid      in   1             fetch offers in_instr/in_pc
//  in_ready      out  1             stage accepts; = (count < DEPTH)
//  in_instr      in   32            instruction word
//  in_pc         in   DATA_WIDTH    address of in_instr
//  flags_nzcv    in   4             CPSR N,Z,C,V (bit3..bit0), sampled at acceptance
//  out_valid     out  1             head entry valid; = (count != 0)
//  out_ready     in   1             execute consumes head entry
//  out_rd/rn/rm  out  4 each        register fields; STR: rm = instr[15:12], rd = 0
//  out_shift     out  8             instr[11:4] for register-operand forms, else 0
//  out_imm       out  DATA_WIDTH    expanded operand-2 immediate (DP with I=1), else 0
//  out_imm_en    out  1             operand 2 is immediate
//  out_set_flags out  1             instr[20] for DP ops; forced 1 for CMP/TST/TEQ; 0 otherwise
//  out_alu_code  out  ALUCTL_WIDTH  operation code (see BEHAVIOUR)
//  out_exec      out  1             condition passed
//  out_is_branch out  1             B or BL;  out_link  out 1  BL only
//  out_br_target out  DATA_WIDTH    branch target
//  out_is_load / out_is_store  out 1 each;  out_dt_offset  out 12  instr[11:0] for LDR/STR
//  out_undef     out  1             word matched no supported class
// BEHAVIOUR
//  - Reset (async): count=0, FIFO ptrs=0, every out_* field reads 0; out_valid=0, in_ready=1.
//  - Push when in_valid&in_ready; pop when out_valid&out_ready; simultaneous push+pop allowed, count unchanged.
//  - in_ready does not depend on out_ready: a full FIFO refuses push even while popping that cycle.
//  - Latency: word accepted at edge N appears on out_* after edge N when FIFO was empty; FIFO order preserved.
//  - flush: count and ptrs -> 0 at next edge; overrides push and pop in the same cycle (the word is dropped).
//  - Outputs are registered FIFO head contents; no combinational path from in_* to out_*.
//  - Decode on instr[27:20]: 00x opcode S -> DP by opcode [24:21]: AND=3 EOR=5 SUB=2 ADD=0 TST=9 TEQ=10
//    CMP=8 ORR=4 MOV=6 BIC=11 MVN=7; opcodes 0011,0101,0110,0111,1011 -> out_undef, alu_code=63.
//    101L -> B=31 (L=0) / BL=32 (L=1); 01xxxxxL -> LDR=41 (L=1) / STR=42 (L=0); others -> undef, code 63.
//  - Undefined entries: out_exec=0, all other fields 0 except out_undef=1; still occupy a FIFO slot.
//  - Immediate: out_imm = zero-extend(ROR32(zext(instr[7:0]), 2*instr[11:8])).
//  - Branch target = in_pc + 8 + (sign-extend(instr[23:0]) << 2), modulo 2^DATA_WIDTH.
//  - Condition (N,Z,C,V from flags_nzcv): 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V;
//    7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
//  - Reset asserted mid-stream discards all entries immediately; no partial entry survives.
// TESTING
//  1 0xE2844001 (ADD r4,r4,#1), pc 0, empty FIFO -> 1 cycle later: valid, code 0, rd=rn=4, imm 1, imm_en 1, exec 1.
//  2 0xE3A004FF (MOV r0,#0xFF000000) -> out_imm 0xFF000000, code 6; 0xE1500001 (CMP r0,r1) -> code 8, set_flags 1.
//  3 0xEAFFFFFE at pc 0x100 -> is_branch 1, link 0, target 0x100; 0xEB000001 at pc 0 -> link 1, target 0x0C.
//  4 0x0A000000 with nzcv 0000 -> exec 0, with 0100 -> exec 1; 0xD... with nzcv 1000 -> exec 1; 0xF... -> 0.
//  5 out_ready=0, push DEPTH words -> in_ready 0; hold 3 cycles, then out_ready=1 -> words out in order, no loss.
//  6 flush with in_valid=1 while 1 entry held -> next cycle out_valid 0, count 0; rst_n low mid-stream -> outputs 0.

Source files
------------

// File: rtl/instruction_decode_stage_if.sv
// Handshake bundle between fetch, the decode stage and execute.
//   master : fetch/execute side (drives in_*, flags, flush, out_ready)
//   slave  : decode stage (drives in_ready and every out_* field)
// Signals:
//   flush              synchronous discard of buffered entries
//   in_valid/in_ready  fetch-side handshake; in_instr, in_pc, flags_nzcv ride with it
//   out_valid/out_ready execute-side handshake; out_* carry the decoded head entry
interface instruction_decode_stage_if #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ALUCTL_WIDTH = 11
);
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [31:0]             in_instr;
  logic [DATA_WIDTH-1:0]   in_pc;
  logic [3:0]              flags_nzcv;
  logic                    out_valid;
  logic                    out_ready;
  logic [3:0]              out_rd;
  logic [3:0]              out_rn;
  logic [3:0]              out_rm;
  logic [7:0]              out_shift;
  logic [DATA_WIDTH-1:0]   out_imm;
  logic                    out_imm_en;
  logic                    out_set_flags;
  logic [ALUCTL_WIDTH-1:0] out_alu_code;
  logic                    out_exec;
  logic                    out_is_branch;
  logic                    out_link;
  logic [DATA_WIDTH-1:0]   out_br_target;
  logic                    out_is_load;
  logic                    out_is_store;
  logic [11:0]             out_dt_offset;
  logic                    out_undef;

  modport master (
    output flush, in_valid, in_instr, in_pc, flags_nzcv, out_ready,
    input  in_ready, out_valid, out_rd, out_rn, out_rm, out_shift, out_imm, out_imm_en,
           out_set_flags, out_alu_code, out_exec, out_is_branch, out_link, out_br_target,
           out_is_load, out_is_store, out_dt_offset, out_undef
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, flags_nzcv, out_ready,
    output in_ready, out_valid, out_rd, out_rn, out_rm, out_shift, out_imm, out_imm_en,
           out_set_flags, out_alu_code, out_exec, out_is_branch, out_link, out_br_target,
           out_is_load, out_is_store, out_dt_offset, out_undef
  );
endinterface

// File: rtl/instruction_decode_stage.sv
// Registered ARM-subset decode stage. Each accepted word is decoded combinationally
// (data-processing, B/BL, LDR/STR, condition check, rotated immediate, branch target)
// and written into a DEPTH-entry FIFO; execute sees the registered FIFO head.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; empties the FIFO and zeroes every output
//   bus    slave side of instruction_decode_stage_if (fetch handshake in, decoded entry out)
module instruction_decode_stage #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ALUCTL_WIDTH = 11,
  parameter int unsigned DEPTH        = 2
) (
  input logic                       clk,
  input logic                       rst_n,
  instruction_decode_stage_if.slave bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [3:0]              rd;
    logic [3:0]              rn;
    logic [3:0]              rm;
    logic [7:0]              shift;
    logic [DATA_WIDTH-1:0]   imm;
    logic                    imm_en;
    logic                    set_flags;
    logic [ALUCTL_WIDTH-1:0] alu;
    logic                    exec;
    logic                    is_branch;
    logic                    link;
    logic [DATA_WIDTH-1:0]   br_target;
    logic                    is_load;
    logic                    is_store;
    logic [11:0]             dt_offset;
    logic                    undef;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Decode of the offered word
  // ---------------------------------------------------------------------------
  logic [31:0]           instr;
  logic                  flag_n, flag_z, flag_c, flag_v;
  logic                  cond_pass;
  logic [3:0]            op;
  logic                  dp_ok;
  logic [ALUCTL_WIDTH-1:0] dp_alu;
  logic [4:0]            rot;
  logic [31:0]           imm8_ext;
  logic [31:0]           imm32;
  logic [DATA_WIDTH-1:0] br_sext;
  entry_t                dec;

  assign instr = bus.in_instr;
  assign {flag_n, flag_z, flag_c, flag_v} = bus.flags_nzcv;

  always_comb begin
    cond_pass = 1'b0;
    unique case (instr[31:28])
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = !flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = !flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = !flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = !flag_v;
      4'h8: cond_pass = flag_c && !flag_z;
      4'h9: cond_pass = !flag_c || flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = !flag_z && (flag_n == flag_v);
      4'hD: cond_pass = flag_z || (flag_n != flag_v);
      4'hE: cond_pass = 1'b1;
      4'hF: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    op     = instr[24:21];
    dp_ok  = 1'b1;
    dp_alu = '0;
    case (op)
      4'b0000: dp_alu = ALUCTL_WIDTH'(3);   // AND
      4'b0001: dp_alu = ALUCTL_WIDTH'(5);   // EOR
      4'b0010: dp_alu = ALUCTL_WIDTH'(2);   // SUB
      4'b0100: dp_alu = ALUCTL_WIDTH'(0);   // ADD
      4'b1000: dp_alu = ALUCTL_WIDTH'(9);   // TST
      4'b1001: dp_alu = ALUCTL_WIDTH'(10);  // TEQ
      4'b1010: dp_alu = ALUCTL_WIDTH'(8);   // CMP
      4'b1100: dp_alu = ALUCTL_WIDTH'(4);   // ORR
      4'b1101: dp_alu = ALUCTL_WIDTH'(6);   // MOV
      4'b1110: dp_alu = ALUCTL_WIDTH'(11);  // BIC
      4'b1111: dp_alu = ALUCTL_WIDTH'(7);   // MVN
      default: dp_ok  = 1'b0;               // RSB/ADC/SBC/RSC/CMN unsupported
    endcase
  end

  // Rotate-right of the 8-bit immediate by twice the 4-bit rotate field.
  // A rotate of 0 makes the left shift 32, which clears that term.
  assign rot      = {instr[11:8], 1'b0};
  assign imm8_ext = {24'd0, instr[7:0]};
  assign imm32    = (imm8_ext >> rot) | (imm8_ext << (6'd32 - {1'b0, rot}));
  assign br_sext  = {{(DATA_WIDTH - 24){instr[23]}}, instr[23:0]};

  always_comb begin
    dec = '0;
    if (instr[27:26] == 2'b00 && dp_ok) begin
      dec.rd        = instr[15:12];
      dec.rn        = instr[19:16];
      if (instr[25]) begin
        dec.imm    = DATA_WIDTH'(imm32);
        dec.imm_en = 1'b1;
      end else begin
        dec.rm    = instr[3:0];
        dec.shift = instr[11:4];
      end
      // Compare/test ops always update flags regardless of the S bit.
      dec.set_flags = instr[20] || (op inside {4'b1000, 4'b1001, 4'b1010});
      dec.alu       = dp_alu;
      dec.exec      = cond_pass;
    end else if (instr[27:25] == 3'b101) begin
      dec.is_branch = 1'b1;
      dec.link      = instr[24];
      dec.alu       = instr[24] ? ALUCTL_WIDTH'(32) : ALUCTL_WIDTH'(31);
      dec.br_target = bus.in_pc + DATA_WIDTH'(8) + (br_sext << 2);
      dec.exec      = cond_pass;
    end else if (instr[27:26] == 2'b01) begin
      dec.rn        = instr[19:16];
      dec.dt_offset = instr[11:0];
      if (instr[20]) begin
        dec.rd      = instr[15:12];
        dec.is_load = 1'b1;
        dec.alu     = ALUCTL_WIDTH'(41);
      end else begin
        // Store data register travels on rm so rd never implies a writeback.
        dec.rm       = instr[15:12];
        dec.is_store = 1'b1;
        dec.alu      = ALUCTL_WIDTH'(42);
      end
      dec.exec = cond_pass;
    end else begin
      dec.undef = 1'b1;
      dec.alu   = ALUCTL_WIDTH'(63);
    end
  end

  // ---------------------------------------------------------------------------
  // Decoded-entry FIFO
  // ---------------------------------------------------------------------------
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;
  entry_t          head;

  assign bus.in_ready  = (count_q < CntW'(DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // Stale slots are masked so an empty stage always presents all-zero fields.
  assign head = bus.out_valid ? mem_q[rd_ptr_q] : '0;

  assign bus.out_rd        = head.rd;
  assign bus.out_rn        = head.rn;
  assign bus.out_rm        = head.rm;
  assign bus.out_shift     = head.shift;
  assign bus.out_imm       = head.imm;
  assign bus.out_imm_en    = head.imm_en;
  assign bus.out_set_flags = head.set_flags;
  assign bus.out_alu_code  = head.alu;
  assign bus.out_exec      = head.exec;
  assign bus.out_is_branch = head.is_branch;
  assign bus.out_link      = head.link;
  assign bus.out_br_target = head.br_target;
  assign bus.out_is_load   = head.is_load;
  assign bus.out_is_store  = head.is_store;
  assign bus.out_dt_offset = head.dt_offset;
  assign bus.out_undef     = head.undef;

endmodule

// File: tb/tb_instruction_decode_stage.sv
module tb_instruction_decode_stage;

  typedef struct packed {
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [7:0]  shift;
    logic [31:0] imm;
    logic        imm_en;
    logic        set_flags;
    logic [10:0] alu;
    logic        exec;
    logic        is_branch;
    logic        link;
    logic [31:0] target;
    logic        is_load;
    logic        is_store;
    logic [11:0] dt_off;
    logic        undef;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  nzcv;
    exp_t        e;
  } vec_t;

  logic clk;
  logic rst_n;

  instruction_decode_stage_if #(.DATA_WIDTH(32), .ALUCTL_WIDTH(11)) bus ();

  instruction_decode_stage #(
    .DATA_WIDTH  (32),
    .ALUCTL_WIDTH(11),
    .DEPTH       (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t cur_exp;
  int   n_vec;
  int   n_miss;

  function automatic void add(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [3:0] nzcv, input exp_t e);
    vec_t v;
    v.instr = instr;
    v.pc    = pc;
    v.nzcv  = nzcv;
    v.e     = e;
    vecs.push_back(v);
  endfunction

  function automatic exp_t act();
    exp_t a;
    a.rd        = bus.out_rd;
    a.rn        = bus.out_rn;
    a.rm        = bus.out_rm;
    a.shift     = bus.out_shift;
    a.imm       = bus.out_imm;
    a.imm_en    = bus.out_imm_en;
    a.set_flags = bus.out_set_flags;
    a.alu       = bus.out_alu_code;
    a.exec      = bus.out_exec;
    a.is_branch = bus.out_is_branch;
    a.link      = bus.out_link;
    a.target    = bus.out_br_target;
    a.is_load   = bus.out_is_load;
    a.is_store  = bus.out_is_store;
    a.dt_off    = bus.out_dt_offset;
    a.undef     = bus.out_undef;
    return a;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Scoreboard step at the falling edge: pop/compare, then record any accepted word.
  task automatic sb_sample();
    exp_t e;
    if (!rst_n || bus.flush) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_output: got %h, want no entry", act());
        end else begin
          e = sb.pop_front();
          check("scoreboard_entry", 128'(act()), 128'(e));
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(cur_exp);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
    sb_sample();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx);
    bus.in_valid   = 1'b1;
    bus.in_instr   = vecs[idx].instr;
    bus.in_pc      = vecs[idx].pc;
    bus.flags_nzcv = vecs[idx].nzcv;
    cur_exp        = vecs[idx].e;
  endtask

  task automatic send(input int idx, input bit rnd);
    bit acc;
    acc = 1'b0;
    drive(idx);
    for (int k = 0; k < 50 && !acc; k++) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      to_neg();
      acc = bus.in_ready;
      to_pos();
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      n_vec++;
      n_miss++;
      $display("FAIL send_timeout: vector %0d got not accepted, want accepted", idx);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      to_neg();
      done = !bus.out_valid && (sb.size() == 0);
      to_pos();
    end
    check("drain_empty", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    exp_t e;
    n_vec          = 0;
    n_miss         = 0;
    rst_n          = 1'b0;
    bus.flush      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_instr   = '0;
    bus.in_pc      = '0;
    bus.flags_nzcv = '0;
    bus.out_ready  = 1'b0;
    cur_exp        = '0;

    // 0 ADD r4,r4,#1
    e = '0; e.rd = 4; e.rn = 4; e.imm = 1; e.imm_en = 1; e.alu = 0; e.exec = 1;
    add(32'hE2844001, 32'h0, 4'b0000, e);
    // 1 MOV r0,#0xFF000000
    e = '0; e.imm = 32'hFF000000; e.imm_en = 1; e.alu = 6; e.exec = 1;
    add(32'hE3A004FF, 32'h10, 4'b0000, e);
    // 2 CMP r0,r1
    e = '0; e.rm = 1; e.set_flags = 1; e.alu = 8; e.exec = 1;
    add(32'hE1500001, 32'h0, 4'b0000, e);
    // 3 B . at 0x100
    e = '0; e.is_branch = 1; e.alu = 31; e.exec = 1; e.target = 32'h100;
    add(32'hEAFFFFFE, 32'h100, 4'b0000, e);
    // 4 BL +1 at 0
    e = '0; e.is_branch = 1; e.link = 1; e.alu = 32; e.exec = 1; e.target = 32'hC;
    add(32'hEB000001, 32'h0, 4'b0000, e);
    // 5/6 BEQ with Z clear / set
    e = '0; e.is_branch = 1; e.alu = 31; e.target = 32'h8;
    add(32'h0A000000, 32'h0, 4'b0000, e);
    e.exec = 1;
    add(32'h0A000000, 32'h0, 4'b0100, e);
    // 7 BLE with N=1,V=0
    e = '0; e.is_branch = 1; e.alu = 31; e.exec = 1; e.target = 32'h48;
    add(32'hDA000000, 32'h40, 4'b1000, e);
    // 8 NV never executes
    e = '0; e.is_branch = 1; e.alu = 31; e.target = 32'h8;
    add(32'hFA000000, 32'h0, 4'b1111, e);
    // 9 LDR r2,[r1,#4]
    e = '0; e.rd = 2; e.rn = 1; e.dt_off = 12'h004; e.is_load = 1; e.alu = 41; e.exec = 1;
    add(32'hE5912004, 32'h0, 4'b0000, e);
    // 10 STR r3,[r2,#8]
    e = '0; e.rn = 2; e.rm = 3; e.dt_off = 12'h008; e.is_store = 1; e.alu = 42; e.exec = 1;
    add(32'hE5823008, 32'h0, 4'b0000, e);
    // 11 ADC (unsupported opcode), 12 coprocessor class, both undefined
    e = '0; e.undef = 1; e.alu = 63;
    add(32'hE0A12003, 32'h0, 4'b0000, e);
    add(32'hEE000000, 32'h0, 4'b0000, e);
    // 13 SUBS r2,r1,r3,LSL #3
    e = '0; e.rd = 2; e.rn = 1; e.rm = 3; e.shift = 8'h18; e.set_flags = 1; e.alu = 2;
    e.exec = 1;
    add(32'hE0512183, 32'h0, 4'b0000, e);
    // 14/15 MOVHI r0,r1 with C=1,Z=0 then C=1,Z=1
    e = '0; e.rm = 1; e.alu = 6; e.exec = 1;
    add(32'h81A00001, 32'h0, 4'b0010, e);
    e.exec = 0;
    add(32'h81A00001, 32'h0, 4'b0110, e);
    // 16 TST r1,#1 encoded with S=0: flags still set
    e = '0; e.rn = 1; e.imm = 1; e.imm_en = 1; e.set_flags = 1; e.alu = 9; e.exec = 1;
    add(32'hE3010001, 32'h0, 4'b0000, e);
    // 17 MOV r0,#2 ROR 2
    e = '0; e.imm = 32'h80000000; e.imm_en = 1; e.alu = 6; e.exec = 1;
    add(32'hE3A00102, 32'h0, 4'b0000, e);
    // 18 ADDLT with N=1,V=0; 19 ADDGT with Z=0,N=0,V=1
    e = '0; e.rd = 4; e.rn = 4; e.imm = 1; e.imm_en = 1; e.alu = 0; e.exec = 1;
    add(32'hB2844001, 32'h0, 4'b1000, e);
    e.exec = 0;
    add(32'hC2844001, 32'h0, 4'b0001, e);
    // 20 EOR r2,r1,r3
    e = '0; e.rd = 2; e.rn = 1; e.rm = 3; e.alu = 5; e.exec = 1;
    add(32'hE0212003, 32'h0, 4'b0000, e);
    // 21 B with most-negative offset wraps
    e = '0; e.is_branch = 1; e.alu = 31; e.exec = 1; e.target = 32'hFE000008;
    add(32'hEA800000, 32'h0, 4'b0000, e);
    // 22 CMN unsupported
    e = '0; e.undef = 1; e.alu = 63;
    add(32'hE1700001, 32'h0, 4'b0000, e);

    // Reset state
    to_neg();
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("rst_fields", 128'(act()), 128'(0));
    #2 rst_n = 1'b1;
    to_pos();

    // One-cycle latency from acceptance to out_valid
    bus.out_ready = 1'b0;
    drive(0);
    to_neg();
    to_pos();
    bus.in_valid = 1'b0;
    to_neg();
    check("latency_out_valid", 128'(bus.out_valid), 128'(1));
    to_pos();
    drain();

    // Table pass with the consumer always ready, then with random backpressure
    bus.out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) send(i, 1'b0);
    drain();
    for (int i = 0; i < vecs.size(); i++) send(i, 1'b1);
    drain();

    // Full FIFO refuses a third word while stalled, then delivers all in order
    bus.out_ready = 1'b0;
    send(0, 1'b0);
    send(1, 1'b0);
    drive(2);
    for (int k = 0; k < 3; k++) begin
      to_neg();
      check("full_in_ready", 128'(bus.in_ready), 128'(0));
      check("full_out_valid", 128'(bus.out_valid), 128'(1));
      to_pos();
    end
    bus.out_ready = 1'b1;
    to_neg();
    check("full_pop_in_ready", 128'(bus.in_ready), 128'(0));
    to_pos();
    send(2, 1'b0);
    drain();

    // Flush with a word offered drops both the held entry and the offered word
    bus.out_ready = 1'b0;
    send(3, 1'b0);
    drive(4);
    bus.flush = 1'b1;
    to_neg();
    to_pos();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    to_neg();
    check("flush_out_valid", 128'(bus.out_valid), 128'(0));
    check("flush_in_ready", 128'(bus.in_ready), 128'(1));
    check("flush_fields", 128'(act()), 128'(0));
    to_pos();
    bus.out_ready = 1'b1;
    send(5, 1'b0);
    drain();

    // Asynchronous reset mid-stream clears everything immediately
    bus.out_ready = 1'b0;
    send(9, 1'b0);
    send(10, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
    check("midrst_in_ready", 128'(bus.in_ready), 128'(1));
    check("midrst_fields", 128'(act()), 128'(0));
    to_neg();
    #2 rst_n = 1'b1;
    to_pos();
    bus.out_ready = 1'b1;
    send(7, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
